// File: rtl/if_id_skid_pkg.sv
// rtl/if_id_skid_pkg.sv - shared constants and state encoding for the fetch-to-decode skid buffer
// Purpose: datapath width, the decode-side NOP word, the FSM state encoding and a payload
//          packing helper. The three FSM states are encoded so that the state value is also
//          the occupancy count.
// Ports:   none (package)
package if_id_skid_pkg;

  localparam int DW = 32;
  localparam logic [DW-1:0] NOP_INST = 32'h0000_0000;

  // Payload is {pc, inst, npc}, pc in the top third.
  localparam int PW = 3 * DW;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = S_EMPTY,
    ST_ONE   = S_ONE,
    ST_FULL  = S_FULL
  } state_t;

  function automatic logic [PW-1:0] pack_payload(input logic [DW-1:0] pc,
                                                 input logic [DW-1:0] inst,
                                                 input logic [DW-1:0] npc);
    return {pc, inst, npc};
  endfunction

endpackage

// File: rtl/if_id_skid_if.sv
// rtl/if_id_skid_if.sv - fetch/decode handshake bundle around the skid buffer
// Purpose: groups the fetch-side beat, the decode-side beat, flush and occupancy.
// Ports:   master - the fetch/decode environment (drives if_*, flush, id_ready)
//          slave  - the skid buffer (drives if_ready, id_*, occupancy)
interface if_id_skid_if #(
  parameter int DW = if_id_skid_pkg::DW
);

  logic          if_valid;
  logic [DW-1:0] if_pc;
  logic [DW-1:0] if_inst;
  logic [DW-1:0] if_npc;
  logic          if_ready;
  logic          flush;
  logic          id_valid;
  logic [DW-1:0] id_pc;
  logic [DW-1:0] id_inst;
  logic [DW-1:0] id_npc;
  logic          id_ready;
  logic [1:0]    occupancy;

  modport master (
    output if_valid, if_pc, if_inst, if_npc, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_inst, id_npc, occupancy
  );

  modport slave (
    input  if_valid, if_pc, if_inst, if_npc, flush, id_ready,
    output if_ready, id_valid, id_pc, id_inst, id_npc, occupancy
  );

endinterface

// File: rtl/if_id_skid_pipe_slot.sv
// rtl/if_id_skid_pipe_slot.sv - load-enabled payload register with valid bit
// Purpose: one storage slot of the skid buffer. rst zeroes payload and valid; clr drops
//          only the valid bit (payload is left as is); load captures d and sets valid.
//          Priority rst > clr > load.
// Ports:   clk, rst   clock, synchronous active-high reset
//          clr        invalidate the slot
//          load       capture d
//          d / q      payload in / out (W bits)
//          valid      slot holds a live entry
module if_id_skid_pipe_slot #(
  parameter int W = if_id_skid_pkg::PW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - 2-entry IF/ID skid buffer with flush and fetch back-pressure
// Purpose: fetch-to-decode pipeline register. The main slot drives decode directly from
//          flops; the skid slot absorbs the one beat that arrives while decode stalls, so
//          if_ready can be a register instead of a combinational path from id_ready.
// Ports:   clk             clock
//          rst             synchronous active-high reset
//          bus.if_*        fetch beat {pc, inst, npc} with if_valid / if_ready
//          bus.flush       drop everything held and the beat offered this cycle
//          bus.id_*        decode beat with id_valid / id_ready; id_inst = NOP_INST when idle
//          bus.occupancy   number of held entries (0..2)
module if_id_skid #(
  parameter int                DW       = if_id_skid_pkg::DW,
  parameter logic [DW-1:0]     NOP_INST = if_id_skid_pkg::NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  if_id_skid_if.slave  bus
);

  import if_id_skid_pkg::*;

  state_t state_q, state_d;

  logic            if_ready_q;
  logic            accept, consume;
  logic            main_load, main_clr, skid_load, skid_clr;
  logic [3*DW-1:0] in_payload, main_d, main_q, skid_q;
  logic            main_valid, skid_valid;

  assign in_payload = {bus.if_pc, bus.if_inst, bus.if_npc};
  assign accept     = bus.if_valid & if_ready_q;
  assign consume    = main_valid & bus.id_ready;

  // Main refills from skid when draining FULL, otherwise straight from fetch.
  assign main_d = (state_q == ST_FULL) ? skid_q : in_payload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // if_ready is the registered "not FULL next cycle"; held low through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_ready_q <= 1'b0;
    end else begin
      if_ready_q <= (state_d != ST_FULL);
    end
  end

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (bus.flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (consume) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
            skid_clr  = 1'b1;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  if_id_skid_pipe_slot #(.W(3*DW)) main (
    .clk   (clk),
    .rst   (rst),
    .clr   (main_clr),
    .load  (main_load),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  if_id_skid_pipe_slot #(.W(3*DW)) skid (
    .clk   (clk),
    .rst   (rst),
    .clr   (skid_clr),
    .load  (skid_load),
    .d     (in_payload),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign bus.if_ready  = if_ready_q;
  assign bus.id_valid  = main_valid;
  assign bus.id_pc     = main_q[3*DW-1:2*DW];
  assign bus.id_inst   = main_valid ? main_q[2*DW-1:DW] : NOP_INST;
  assign bus.id_npc    = main_q[DW-1:0];
  assign bus.occupancy = state_q;

  a_occ_max: assert property (@(posedge clk) disable iff (rst)
    (state_q != 2'd3) && (skid_valid == (state_q == ST_FULL)));

  a_no_accept_full: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_FULL) |-> !accept);

  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    $past(main_valid && !bus.id_ready && !bus.flush && !rst) |->
      (main_valid && (main_q == $past(main_q))));

endmodule

// File: tb/tb_if_id_skid.sv
// tb/tb_if_id_skid.sv - directed and scoreboarded bench for if_id_skid
module tb_if_id_skid;

  logic clk = 1'b0;
  logic rst;

  if_id_skid_if bus ();

  if_id_skid dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = 32'h2001_0000 + (pc >> 2);
    bus.if_npc   = pc + 32'd4;
  endtask

  task automatic expect_id(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] occ);
    check({tag, "_valid"}, {31'd0, bus.id_valid}, {31'd0, v});
    if (v) begin
      check({tag, "_pc"},   bus.id_pc,   pc);
      check({tag, "_inst"}, bus.id_inst, 32'h2001_0000 + (pc >> 2));
      check({tag, "_npc"},  bus.id_npc,  pc + 32'd4);
    end else begin
      check({tag, "_inst"}, bus.id_inst, 32'h0000_0000);
    end
    check({tag, "_occ"}, {30'd0, bus.occupancy}, occ);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sb[$];
    logic [31:0] next_pc;
    logic        exp_ready, acc, con;

    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b0;
    offer(1'b1, 32'h100);

    // 1. reset held 3 cycles with if_valid high
    for (int i = 0; i < 3; i++) begin
      cyc();
      expect_id("rst", 1'b0, 32'h0, 32'd0);
      check("rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
    end
    check("rst_id_pc",  bus.id_pc,  32'h0);
    check("rst_id_npc", bus.id_npc, 32'h0);
    rst = 1'b0;
    cyc();
    check("rel_if_ready", {31'd0, bus.if_ready}, 32'd1);
    expect_id("rel", 1'b0, 32'h0, 32'd0);

    // 2. streaming at full throughput
    bus.id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 32'(i * 4));
      cyc();
      expect_id("stream", 1'b1, 32'(i * 4), 32'd1);
      check("stream_if_ready", {31'd0, bus.if_ready}, 32'd1);
    end
    offer(1'b0, 32'h0);
    cyc();
    expect_id("stream_end", 1'b0, 32'h0, 32'd0);

    // 3. stall into skid, then release in order
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'(i * 4));
      cyc();
    end
    expect_id("pre_stall", 1'b1, 32'h8, 32'd1);
    bus.id_ready = 1'b0;
    offer(1'b1, 32'hC);
    cyc();
    expect_id("stall", 1'b1, 32'h8, 32'd2);
    check("stall_if_ready", {31'd0, bus.if_ready}, 32'd0);
    offer(1'b1, 32'h10);
    cyc();
    expect_id("stall_hold", 1'b1, 32'h8, 32'd2);
    bus.id_ready = 1'b1;
    cyc();
    expect_id("release_c", 1'b1, 32'hC, 32'd1);
    check("release_if_ready", {31'd0, bus.if_ready}, 32'd1);
    cyc();
    expect_id("release_10", 1'b1, 32'h10, 32'd1);
    offer(1'b0, 32'h0);
    cyc();
    expect_id("release_end", 1'b0, 32'h0, 32'd0);

    // 4. flush while FULL with if_valid asserted
    bus.id_ready = 1'b0;
    offer(1'b1, 32'h20);
    cyc();
    offer(1'b1, 32'h24);
    cyc();
    expect_id("pre_flush", 1'b1, 32'h20, 32'd2);
    offer(1'b1, 32'h28);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    expect_id("flush_full", 1'b0, 32'h0, 32'd0);
    check("flush_if_ready", {31'd0, bus.if_ready}, 32'd1);
    offer(1'b0, 32'h0);
    bus.id_ready = 1'b1;
    cyc();
    expect_id("flush_after", 1'b0, 32'h0, 32'd0);

    // flush in ONE while a handshake happens: the accepted beat is dropped
    bus.id_ready = 1'b0;
    offer(1'b1, 32'h30);
    cyc();
    offer(1'b1, 32'h34);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    expect_id("flush_one", 1'b0, 32'h0, 32'd0);
    offer(1'b0, 32'h0);
    cyc();
    expect_id("flush_one_after", 1'b0, 32'h0, 32'd0);

    // 5. random id_ready against a queue model
    next_pc = 32'h100;
    for (int i = 0; i < 20; i++) begin
      offer(($urandom_range(0, 3) != 0), next_pc);
      bus.id_ready = 1'($urandom_range(0, 1));
      exp_ready = (sb.size() < 2);
      check("sb_if_ready", {31'd0, bus.if_ready}, {31'd0, exp_ready});
      check("sb_occ", {30'd0, bus.occupancy}, 32'(sb.size()));
      check("sb_valid", {31'd0, bus.id_valid}, {31'd0, (sb.size() > 0)});
      if (sb.size() > 0) check("sb_pc", bus.id_pc, sb[0]);
      acc = bus.if_valid && exp_ready;
      con = (sb.size() > 0) && bus.id_ready;
      cyc();
      if (con) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(next_pc);
        next_pc = next_pc + 32'd4;
      end
    end
    offer(1'b0, 32'h0);
    bus.id_ready = 1'b1;
    for (int k = 0; k < 4 && sb.size() > 0; k++) begin
      check("drain_pc", bus.id_pc, sb[0]);
      check("drain_valid", {31'd0, bus.id_valid}, 32'd1);
      cyc();
      void'(sb.pop_front());
    end
    expect_id("drain_end", 1'b0, 32'h0, 32'd0);

    // 6. reset pulse while FULL, then restart
    bus.id_ready = 1'b0;
    offer(1'b1, 32'h200);
    cyc();
    offer(1'b1, 32'h204);
    cyc();
    expect_id("pre_rst", 1'b1, 32'h200, 32'd2);
    offer(1'b1, 32'h208);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    expect_id("mid_rst", 1'b0, 32'h0, 32'd0);
    check("mid_rst_pc",  bus.id_pc,  32'h0);
    check("mid_rst_npc", bus.id_npc, 32'h0);
    check("mid_rst_if_ready", {31'd0, bus.if_ready}, 32'd0);
    cyc();
    check("post_rst_if_ready", {31'd0, bus.if_ready}, 32'd1);
    expect_id("post_rst", 1'b0, 32'h0, 32'd0);
    bus.id_ready = 1'b1;
    offer(1'b1, 32'h40);
    cyc();
    expect_id("restart", 1'b1, 32'h40, 32'd1);
    offer(1'b0, 32'h0);
    cyc();
    expect_id("restart_end", 1'b0, 32'h0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
